// File: rtl/dmem_resp_bridge_pkg.sv
// Shared definitions for the data-request responder bridge: FSM state
// encodings, access-size encodings, default timeout/error values and the
// captured request bundle.
package dmem_resp_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  localparam int unsigned         TIMEOUT_CYC_DEF = 255;
  localparam logic [DATA_W-1:0]   ERR_RDATA_DEF   = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Loads never drive byte enables downstream.
  function automatic logic [STRB_W-1:0] eff_wstrb(input req_t r);
    return r.wr ? r.wstrb : 4'b0000;
  endfunction

  // Stores always answer with zero data; loads return the given word.
  function automatic logic [DATA_W-1:0] resp_rdata(input logic wr, input logic [DATA_W-1:0] d);
    return wr ? 32'h0000_0000 : d;
  endfunction

endpackage

// File: rtl/dmem_resp_bridge_req_latch.sv
// Holds the request fields captured at accept time and the uncache
// attribute captured in the CHECK cycle; both stay stable until reloaded.
module dmem_resp_bridge_req_latch
  import dmem_resp_bridge_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  req_t req_i,
  input  logic uncache_load_i,
  input  logic uncache_i,
  output req_t req_o,
  output logic uncache_o
);

  req_t req_q, req_d;
  logic uncache_q, uncache_d;

  // Select new contents only on the corresponding load strobe.
  always_comb begin
    if (load_i) begin
      req_d = req_i;
    end else begin
      req_d = req_q;
    end
    if (uncache_load_i) begin
      uncache_d = uncache_i;
    end else begin
      uncache_d = uncache_q;
    end
  end

  // Capture registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_q     <= '0;
      uncache_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      uncache_q <= uncache_d;
    end
  end

  assign req_o     = req_q;
  assign uncache_o = uncache_q;

endmodule

// File: rtl/dmem_resp_bridge.sv
// Responder for the CPU data-request interface. Accepts one request at a
// time (addr_ok/data_ok), resolves MEM-stage cancel/uncache in CHECK, and
// serialises it onto a req/gnt/rvalid memory port.
// Optional feature: define DMEM_RESP_TIMEOUT_EN to force an error response
// (bus_err pulse, ERR_RDATA) when WAIT_RESP lasts too long.
module dmem_resp_bridge
  import dmem_resp_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        data_uncache_en,
  input  logic        tlb_excp_cancel_req,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_uncache,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept_s;
  logic              uncache_load_s;
  logic              to_fire_s;
  req_t              req_in_s;
  req_t              req_s;
  logic              uncache_s;

  // Reset gating keeps a requester from seeing an accept that reset discards.
  assign accept_s     = data_req && !flush && !reset &&
                        ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign data_addr_ok = accept_s;

  assign req_in_s = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};

  dmem_resp_bridge_req_latch u_req_latch (
    .clk_i          (clk),
    .reset_i        (reset),
    .load_i         (accept_s),
    .req_i          (req_in_s),
    .uncache_load_i (uncache_load_s),
    .uncache_i      (data_uncache_en),
    .req_o          (req_s),
    .uncache_o      (uncache_s)
  );

  assign mem_we      = req_s.wr;
  assign mem_size    = req_s.size;
  assign mem_wstrb   = eff_wstrb(req_s);
  assign mem_addr    = req_s.addr;
  assign mem_wdata   = req_s.wdata;
  assign mem_uncache = uncache_s;
  assign data_rdata  = rdata_q;

`ifdef DMEM_RESP_TIMEOUT_EN
  localparam int unsigned      CNT_W   = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  // Firing on this count makes the forced response land TIMEOUT_CYC cycles
  // after the grant cycle (the counter reads 0 in the first WAIT_RESP cycle).
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q;

  // Counter is zero on entry to WAIT_RESP and counts every cycle spent there.
  always_comb begin
    if (state_q == ST_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT_RESP) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign to_fire_s = (state_q == ST_WAIT_RESP) && !mem_rvalid && (cnt_q == TO_LAST);

  // Timeout counter and the bus_err pulse aligned with the RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= to_fire_s;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign to_fire_s = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // FSM state, drop flag and response data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; a granted bus transaction is always seen through.
  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    uncache_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_CHECK;
        else          state_d = ST_IDLE;
      end
      ST_CHECK: begin
        if (flush || tlb_excp_cancel_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d        = ST_ISSUE;
          uncache_load_s = 1'b1;
        end
      end
      ST_ISSUE: begin
        // mem_req is withdrawn combinationally under flush, so no grant can pair with it.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_gnt) begin
          state_d = ST_WAIT_RESP;
          drop_d  = 1'b0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RESP: begin
        if (mem_rvalid || to_fire_s) begin
          if (drop_q || flush) state_d = ST_IDLE;
          else                 state_d = ST_RESP;
          drop_d = 1'b0;
        end else begin
          drop_d = drop_q | flush;
        end
      end
      ST_RESP: begin
        if (accept_s) state_d = ST_CHECK;
        else          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Output decode and response-data selection.
  always_comb begin
    mem_req      = 1'b0;
    data_data_ok = 1'b0;
    rdata_d      = rdata_q;
    case (state_q)
      ST_ISSUE: begin
        if (flush) mem_req = 1'b0;
        else       mem_req = 1'b1;
      end
      ST_WAIT_RESP: begin
        if (mem_rvalid) begin
          rdata_d = resp_rdata(req_s.wr, mem_rdata);
        end else if (to_fire_s) begin
          rdata_d = resp_rdata(req_s.wr, ERR_RDATA);
        end else begin
          rdata_d = rdata_q;
        end
      end
      ST_RESP: begin
        data_data_ok = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_resp_bridge.sv
// Directed, table-driven bench for dmem_resp_bridge plus hand-written
// sequences for reset mid-transaction and WAIT_RESP timeout behaviour.
module tb_dmem_resp_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        data_uncache_en, tlb_excp_cancel_req, flush;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_uncache, mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  always #5 clk = ~clk;

  dmem_resp_bridge #(.TIMEOUT_CYC(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .data_uncache_en(data_uncache_en), .tlb_excp_cancel_req(tlb_excp_cancel_req),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_uncache(mem_uncache), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        unc, cancel, fl, gnt, rvalid;
    logic [31:0] mrdata;
    logic        e_aok, e_dok;
    logic [31:0] e_rdata;
    logic        e_mreq, e_we;
    logic [3:0]  e_wstrb;
    logic        e_unc;
    logic [31:0] e_maddr, e_mwdata;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] req, wr, size, wstrb, addr, wdata,
                              unc, cancel, fl, gnt, rvalid, mrdata,
                              e_aok, e_dok, e_rdata, e_mreq, e_we, e_wstrb, e_unc,
                              e_maddr, e_mwdata);
    vec_t v;
    v.req = req[0]; v.wr = wr[0]; v.size = size[1:0]; v.wstrb = wstrb[3:0];
    v.addr = addr; v.wdata = wdata; v.unc = unc[0]; v.cancel = cancel[0];
    v.fl = fl[0]; v.gnt = gnt[0]; v.rvalid = rvalid[0]; v.mrdata = mrdata;
    v.e_aok = e_aok[0]; v.e_dok = e_dok[0]; v.e_rdata = e_rdata;
    v.e_mreq = e_mreq[0]; v.e_we = e_we[0]; v.e_wstrb = e_wstrb[3:0];
    v.e_unc = e_unc[0]; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    return v;
  endfunction

  task automatic drive_zero();
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0; data_uncache_en = 1'b0;
    tlb_excp_cancel_req = 1'b0; flush = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    data_req = v.req; data_wr = v.wr; data_size = v.size; data_wstrb = v.wstrb;
    data_addr = v.addr; data_wdata = v.wdata; data_uncache_en = v.unc;
    tlb_excp_cancel_req = v.cancel; flush = v.fl; mem_gnt = v.gnt;
    mem_rvalid = v.rvalid; mem_rdata = v.mrdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_k;
    int cnt_dok, cnt_err, cnt_aok;
    drive_zero();
    reset = 1'b1;

    // Columns: req wr size wstrb addr wdata | unc cancel flush gnt rvalid mrdata |
    //          e_aok e_dok e_rdata | e_mreq e_we e_wstrb e_unc e_maddr e_mwdata
    // Load word 0x1000, zero-wait memory.
    vecs.push_back(mk(1,0,2,0,'h1000,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,1,0,0,           0,0,0,           1,0,0,0,'h1000,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,1,'h12345678,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,1,'h12345678,  0,0,0,0,0,0));
    // Uncached half store with one grant wait state; stores answer zero data.
    vecs.push_back(mk(1,1,1,3,'h2004,'hAABBCCDD, 0,0,0,0,0,0,  1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      1,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           1,1,3,1,'h2004,'hAABBCCDD));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,1,0,0,           0,0,0,           1,1,3,1,'h2004,'hAABBCCDD));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,1,'h55555555,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,1,0,           0,0,0,0,0,0));
    // TLB cancel in CHECK, then an immediate new request.
    vecs.push_back(mk(1,0,2,0,'h3000,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,1,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h3008,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,1,0,0,           0,0,0,           1,0,0,0,'h3008,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,1,'hCAFEF00D,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,1,'hCAFEF00D,  0,0,0,0,0,0));
    // Flush in WAIT_RESP, rvalid three cycles later: response dropped.
    vecs.push_back(mk(1,0,2,0,'h4000,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,1,0,0,           0,0,0,           1,0,0,0,'h4000,0));
    vecs.push_back(mk(1,0,2,0,'h4010,0, 0,0,1,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h4010,0, 0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h4010,0, 0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h4010,0, 0,0,0,0,1,'h99999999,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h4010,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,1,0,0,           0,0,0,           1,0,0,0,'h4010,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,1,'h0BADC0DE,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,1,'h0BADC0DE,  0,0,0,0,0,0));
    // Back-to-back loads with data_req held high.
    vecs.push_back(mk(1,0,2,0,'h5000,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h5004,0, 0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h5004,0, 0,0,0,1,0,0,           0,0,0,           1,0,0,0,'h5000,0));
    vecs.push_back(mk(1,0,2,0,'h5004,0, 0,0,0,0,1,'h11111111,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h5004,0, 0,0,0,0,0,0,           1,1,'h11111111,  0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,1,0,0,           0,0,0,           1,0,0,0,'h5004,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,1,'h22222222,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,1,'h22222222,  0,0,0,0,0,0));
    // Flush in ISSUE withdraws mem_req; flush in CHECK and in IDLE.
    vecs.push_back(mk(1,0,2,0,'h6000,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,1,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h7000,0, 0,0,0,0,0,0,           1,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,1,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,'h7004,0, 0,0,1,0,0,0,           0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,1,'hFFFFFFFF,  0,0,0,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,      0,0,0,0,0,0,           0,0,0,           0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst addr_ok", data_addr_ok, 0);
    chk("rst data_ok", data_data_ok, 0);
    chk("rst rdata", data_rdata, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_size", mem_size, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_uncache", mem_uncache, 0);
    chk("rst bus_err", bus_err, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d addr_ok", i), data_addr_ok, vecs[i].e_aok);
      chk($sformatf("v%0d data_ok", i), data_data_ok, vecs[i].e_dok);
      chk($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_mreq);
      chk($sformatf("v%0d bus_err", i), bus_err, 0);
      if (vecs[i].e_dok) chk($sformatf("v%0d rdata", i), data_rdata, vecs[i].e_rdata);
      if (vecs[i].e_mreq) begin
        chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("v%0d mem_wstrb", i), mem_wstrb, vecs[i].e_wstrb);
        chk($sformatf("v%0d mem_uncache", i), mem_uncache, vecs[i].e_unc);
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      end
    end

    // Reset in WAIT_RESP abandons the transaction.
    @(negedge clk); drive_zero(); data_req = 1'b1; data_size = 2'd2; data_addr = 32'h0000_8000;
    #1 chk("mid accept", data_addr_ok, 1);
    @(negedge clk); drive_zero();
    @(negedge clk); mem_gnt = 1'b1;
    #1 chk("mid mem_req", mem_req, 1);
    @(negedge clk); drive_zero(); reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk); drive_zero(); reset = 1'b0;
    #1;
    chk("post-rst data_ok", data_data_ok, 0);
    chk("post-rst mem_req", mem_req, 0);
    chk("post-rst rdata", data_rdata, 0);
    chk("post-rst mem_addr", mem_addr, 0);
    cnt_dok = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (data_data_ok) cnt_dok++;
    end
    chk("post-rst no data_ok", cnt_dok, 0);

    // Grant, then no response: behaviour depends on the timeout option.
    @(negedge clk); drive_zero(); data_req = 1'b1; data_size = 2'd2; data_addr = 32'h0000_9000;
    #1 chk("to accept", data_addr_ok, 1);
    @(negedge clk); drive_zero();
    @(negedge clk); mem_gnt = 1'b1;
    #1 chk("to mem_req", mem_req, 1);
`ifdef DMEM_RESP_TIMEOUT_EN
    seen_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); drive_zero(); #1;
      if (data_data_ok) begin
        seen_k = k;
        chk("to bus_err", bus_err, 1);
        chk("to rdata", data_rdata, 32'hDEAD_BEEF);
        break;
      end
    end
    chk("to latency", seen_k, 8);
    @(negedge clk); #1;
    chk("to bus_err after", bus_err, 0);
    chk("to data_ok after", data_data_ok, 0);
`else
    cnt_dok = 0; cnt_err = 0; cnt_aok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); drive_zero(); data_req = 1'b1; data_addr = 32'h0000_A000; #1;
      if (data_data_ok) cnt_dok++;
      if (bus_err) cnt_err++;
      if (data_addr_ok) cnt_aok++;
    end
    chk("wait no data_ok", cnt_dok, 0);
    chk("wait no bus_err", cnt_err, 0);
    chk("wait no addr_ok", cnt_aok, 0);
    @(negedge clk); drive_zero(); mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk); drive_zero(); #1;
    chk("late data_ok", data_data_ok, 1);
    chk("late rdata", data_rdata, 32'h1357_9BDF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
